datapath_arbiter: RTL and testbench

Shares the processor datapath's register file and bus between up to NREQ requesters (control FSM, debug port, host loader, etc.) with round-robin fairness and optional bounded locking. Each granted transaction performs one register read or write by driving one-hot register enables toward the datapath, then returns an ack (and read data) to the requester. Sits between the requesters and the datapath's `reg_enable_in` / `reg_enable_out` / bus connections.

---
 rtl/datapath_arbiter.sv | 150 +++++++++++++++
 tb/tb_datapath_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin, lock-capable arbiter that shares the
// datapath register file and bus among NREQ requesters.
module datapath_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREG     = 8,
  parameter int DW       = 16,
  parameter int MAXBURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*3-1:0] reg_sel,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [DW-1:0]     bus_rdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic [NREG-1:0]   reg_en_in,
  output logic [NREG-1:0]   reg_en_out,
  output logic [DW-1:0]     bus_wdata,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BMAX  = BW'(MAXBURST);
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
  localparam logic [3:0]    NREG4 = 4'(NREG);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, ACK} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   ptr, ptr_n, nxt;
  logic [BW-1:0]   burst, burst_n;
  logic            lat_we;
  logic [2:0]      lat_sel;
  logic [DW-1:0]   lat_wdata;
  logic            err_flag;
  logic            sel_ok;
  logic            wr_go;
  logic            rd_go;
  logic [IW:0]     win_idle;
  logic [IW:0]     win_rel;
  logic [NREQ-1:0] owner_oh;

  // {found, index} of the first set bit searching start, start+1, ...
  function automatic logic [IW:0] pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   start
  );
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(start) + k) % NREQ;
      if (r[j]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  assign nxt      = (owner == LAST) ? '0 : owner + IW'(1);
  assign owner_oh = NREQ'(1) << owner;
  assign win_idle = pick(req, ptr);
  assign win_rel  = pick(req & ~owner_oh, nxt);
  assign sel_ok   = {1'b0, lat_sel} < NREG4;
  assign wr_go    = (state == XFER) && sel_ok && lat_we;
  assign rd_go    = (state == XFER) && sel_ok && !lat_we;

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    burst_n = burst;
    unique case (state)
      IDLE: begin
        if (win_idle[IW]) begin
          state_n = GRANT;
          owner_n = win_idle[IW-1:0];
          burst_n = BW'(1);
        end
      end
      GRANT: state_n = XFER;
      XFER:  state_n = ACK;
      ACK: begin
        if (lock[owner] && req[owner] && burst < BMAX) begin
          state_n = GRANT;
          burst_n = burst + BW'(1);
        end else begin
          ptr_n   = nxt;
          burst_n = '0;
          state_n = IDLE;
          if (win_rel[IW]) begin
            state_n = GRANT;
            owner_n = win_rel[IW-1:0];
            burst_n = BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      burst <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      burst <= burst_n;
    end
  end

  // Fields are sampled once per transaction so later changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      lat_wdata <= '0;
      err_flag  <= 1'b0;
      rdata     <= '0;
    end else begin
      if (state == GRANT) begin
        lat_we    <= we[owner];
        lat_sel   <= reg_sel[3*owner +: 3];
        lat_wdata <= wdata[DW*owner +: DW];
      end
      if (state == XFER) begin
        err_flag <= !sel_ok;
        if (rd_go) rdata <= bus_rdata;
      end
    end
  end

  assign busy       = state != IDLE;
  assign gnt        = busy ? owner_oh : '0;
  assign ack        = (state == ACK) ? owner_oh : '0;
  assign err        = (state == ACK) && err_flag;
  assign reg_en_in  = wr_go ? NREG'(1) << lat_sel : '0;
  assign reg_en_out = rd_go ? NREG'(1) << lat_sel : '0;
  assign bus_wdata  = wr_go ? lat_wdata : '0;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: scenario tasks with a scoreboard queue of
// expected acks (owner, err, rdata) for datapath_arbiter.
module tb_datapath_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int DW   = 16;

  typedef struct {
    int          idx;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   we;
  logic [NREQ*3-1:0] reg_sel;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]     bus_rdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic [NREG-1:0]   reg_en_in;
  logic [NREG-1:0]   reg_en_out;
  logic [DW-1:0]     bus_wdata;
  logic              busy;

  exp_t        sbq[$];
  exp_t        e;
  logic [15:0] exp_rdata;
  int          tests_run = 0;
  int          tests_failed = 0;

  datapath_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .DW(DW), .MAXBURST(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .reg_sel(reg_sel), .wdata(wdata), .bus_rdata(bus_rdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .reg_en_in(reg_en_in), .reg_en_out(reg_en_out),
    .bus_wdata(bus_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [2:0] s, input logic [15:0] d);
    req[i]          = 1'b1;
    we[i]           = w;
    reg_sel[3*i +: 3] = s;
    wdata[16*i +: 16] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req = '0; lock = '0; we = '0;
    reg_sel = '0; wdata = '0; bus_rdata = '0;
    tick();
    tick();
    rst = 1'b1;
    sbq.delete();
    exp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; lock = '0; we = '0;
    reg_sel = '0; wdata = '0; bus_rdata = '0;
    #1;
    tests_run++;
    if ({gnt, ack, err, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got gnt=%b ack=%b err=%b busy=%b, want all 0",
               gnt, ack, err, busy);
    end
    tests_run++;
    if ({reg_en_in, reg_en_out, bus_wdata, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got en_in=%h en_out=%h wd=%h rd=%h, want 0",
               reg_en_in, reg_en_out, bus_wdata, rdata);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    reset_dut();
    set_req(1, 1'b1, 3'd3, 16'hBEEF);
    sbq.push_back('{1, 1'b0, exp_rdata});
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_gnt: got gnt=%b busy=%b, want 0010 1", gnt, busy);
    end
    tick();
    tests_run++;
    if (reg_en_in !== 6'h08 || bus_wdata !== 16'hBEEF || reg_en_out !== '0) begin
      tests_failed++;
      $display("FAIL wr_xfer: got en_in=%h wd=%h en_out=%h, want 08 beef 00",
               reg_en_in, bus_wdata, reg_en_out);
    end
    tick();
    e = sbq.pop_front();
    tests_run++;
    if (ack !== 4'(1 << e.idx) || err !== e.err || rdata !== e.rdata) begin
      tests_failed++;
      $display("FAIL wr_ack: got ack=%b err=%b rd=%h, want idx %0d err=%b rd=%h",
               ack, err, rdata, e.idx, e.err, e.rdata);
    end
    req = '0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || gnt !== '0 || ack !== '0) begin
      tests_failed++;
      $display("FAIL wr_idle: got busy=%b gnt=%b ack=%b, want 0 0 0",
               busy, gnt, ack);
    end
  endtask

  task automatic test_single_read();
    reset_dut();
    bus_rdata = 16'h1234;
    set_req(2, 1'b0, 3'd5, 16'h0000);
    sbq.push_back('{2, 1'b0, 16'h1234});
    exp_rdata = 16'h1234;
    tick();
    tick();
    tests_run++;
    if (reg_en_out !== 6'h20 || reg_en_in !== '0 || bus_wdata !== '0) begin
      tests_failed++;
      $display("FAIL rd_xfer: got en_out=%h en_in=%h wd=%h, want 20 00 0000",
               reg_en_out, reg_en_in, bus_wdata);
    end
    tick();
    e = sbq.pop_front();
    tests_run++;
    if (ack !== 4'(1 << e.idx) || err !== e.err || rdata !== e.rdata) begin
      tests_failed++;
      $display("FAIL rd_ack: got ack=%b err=%b rd=%h, want idx %0d err=%b rd=%h",
               ack, err, rdata, e.idx, e.err, e.rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int gap;
    reset_dut();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 3'(i), 16'(16'hA000 + i));
    sbq.push_back('{0, 1'b0, exp_rdata});
    sbq.push_back('{1, 1'b0, exp_rdata});
    sbq.push_back('{2, 1'b0, exp_rdata});
    sbq.push_back('{3, 1'b0, exp_rdata});
    sbq.push_back('{0, 1'b0, exp_rdata});
    for (int n = 0; n < 5; n++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (ack == '0 && gap < 8);
      tests_run++;
      if (ack == '0 || sbq.size() == 0) begin
        tests_failed++;
        $display("FAIL rr_timeout: no ack within %0d cycles, want ack in 3", gap);
        break;
      end
      e = sbq.pop_front();
      if (ack !== 4'(1 << e.idx) || gap != 3) begin
        tests_failed++;
        $display("FAIL rr_order: got ack=%b gap=%0d, want idx %0d gap 3",
                 ack, gap, e.idx);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock_burst();
    int gap;
    reset_dut();
    set_req(0, 1'b1, 3'd0, 16'h0101);
    set_req(3, 1'b1, 3'd1, 16'h0303);
    lock[0] = 1'b1;
    for (int k = 0; k < 4; k++)
      sbq.push_back('{0, 1'b0, exp_rdata});
    sbq.push_back('{3, 1'b0, exp_rdata});
    sbq.push_back('{0, 1'b0, exp_rdata});
    for (int n = 0; n < 6; n++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (ack == '0 && gap < 8);
      tests_run++;
      if (ack == '0 || sbq.size() == 0) begin
        tests_failed++;
        $display("FAIL lk_timeout: no ack within %0d cycles, want ack in 3", gap);
        break;
      end
      e = sbq.pop_front();
      if (ack !== 4'(1 << e.idx) || gap != 3) begin
        tests_failed++;
        $display("FAIL lk_order: ack #%0d got ack=%b gap=%0d, want idx %0d gap 3",
                 n, ack, gap, e.idx);
      end
      if (e.idx == 3) req[3] = 1'b0;
    end
    req = '0;
    lock = '0;
    tick();
  endtask

  task automatic test_bad_index();
    reset_dut();
    bus_rdata = 16'h5A5A;
    set_req(0, 1'b0, 3'd1, 16'h0000);
    sbq.push_back('{0, 1'b0, 16'h5A5A});
    exp_rdata = 16'h5A5A;
    repeat (3) tick();
    e = sbq.pop_front();
    tests_run++;
    if (ack !== 4'(1 << e.idx) || err !== e.err || rdata !== e.rdata) begin
      tests_failed++;
      $display("FAIL bad_pre: got ack=%b err=%b rd=%h, want idx %0d err=%b rd=%h",
               ack, err, rdata, e.idx, e.err, e.rdata);
    end
    req = '0;
    tick();
    bus_rdata = 16'hFFFF;
    set_req(0, 1'b0, 3'd7, 16'h0000);
    sbq.push_back('{0, 1'b1, exp_rdata});
    tick();
    tick();
    tests_run++;
    if (reg_en_in !== '0 || reg_en_out !== '0 || bus_wdata !== '0) begin
      tests_failed++;
      $display("FAIL bad_en: got en_in=%h en_out=%h wd=%h, want 0 0 0",
               reg_en_in, reg_en_out, bus_wdata);
    end
    tick();
    e = sbq.pop_front();
    tests_run++;
    if (ack !== 4'(1 << e.idx) || err !== e.err || rdata !== e.rdata) begin
      tests_failed++;
      $display("FAIL bad_ack: got ack=%b err=%b rd=%h, want idx %0d err=%b rd=%h",
               ack, err, rdata, e.idx, e.err, e.rdata);
    end
    req = '0;
    tick();
    tests_run++;
    if (err !== 1'b0 || ack !== '0) begin
      tests_failed++;
      $display("FAIL bad_pulse: got err=%b ack=%b after ack cycle, want 0 0",
               err, ack);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int stray;
    reset_dut();
    set_req(2, 1'b1, 3'd0, 16'h2222);
    repeat (3) tick();
    tests_run++;
    if (ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mr_pre: got ack=%b, want 0100", ack);
    end
    req = '0;
    tick();
    set_req(1, 1'b1, 3'd2, 16'h7777);
    tick();
    tests_run++;
    if (gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL mr_gnt1: got gnt=%b, want 0010", gnt);
    end
    tick();
    tests_run++;
    if (reg_en_in !== 6'h04 || bus_wdata !== 16'h7777) begin
      tests_failed++;
      $display("FAIL mr_xfer: got en_in=%h wd=%h, want 04 7777",
               reg_en_in, bus_wdata);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({gnt, ack, err, busy, reg_en_in, reg_en_out, bus_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL mr_async: got gnt=%b ack=%b busy=%b en_in=%h wd=%h, want 0",
               gnt, ack, busy, reg_en_in, bus_wdata);
    end
    sbq.delete();
    stray = 0;
    repeat (3) begin
      tick();
      if (ack !== '0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL mr_noack: got %0d ack cycles in reset, want 0", stray);
    end
    rst = 1'b1;
    req = '0;
    bus_rdata = 16'h4321;
    set_req(2, 1'b0, 3'd4, 16'h0000);
    set_req(3, 1'b1, 3'd3, 16'h3333);
    sbq.push_back('{2, 1'b0, 16'h4321});
    tick();
    tests_run++;
    if (gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mr_gnt2: got gnt=%b, want 0100", gnt);
    end
    tick();
    tick();
    e = sbq.pop_front();
    tests_run++;
    if (ack !== 4'(1 << e.idx) || err !== e.err || rdata !== e.rdata) begin
      tests_failed++;
      $display("FAIL mr_ack: got ack=%b err=%b rd=%h, want idx %0d err=%b rd=%h",
               ack, err, rdata, e.idx, e.err, e.rdata);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_bad_index();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
